// File: rtl/axis_byte_packer_if.sv
// Signal bundle between the UART byte side and the AXI-Stream word side of the packer.
// The master modport is the packer's view. The slave modport is the view of whatever drives the bytes and drains the words.
interface axis_byte_packer_if #(
    parameter int BITS_PER_WORD = 8,
    parameter int W_OUT         = 12
);
    logic                     s_valid;
    logic [BITS_PER_WORD-1:0] s_data;
    logic                     m_ready;
    logic                     m_valid;
    logic [W_OUT-1:0]         m_data;
    logic                     overflow;
    logic                     frame_drop;

    modport master (
        input  s_valid, s_data, m_ready,
        output m_valid, m_data, overflow, frame_drop
    );

    modport slave (
        output s_valid, s_data, m_ready,
        input  m_valid, m_data, overflow, frame_drop
    );
endinterface

// File: rtl/axis_byte_packer.sv
// Packs LSB-first UART bytes into W_OUT-bit words behind a single-entry AXI-Stream output register.
// A partial word is discarded after an inter-byte gap, and completed words are dropped while the output register is full.
module axis_byte_packer #(
    parameter int BITS_PER_WORD = 8,
    parameter int W_OUT         = 12,
    parameter int TIMEOUT_CLKS  = 2_000_000
) (
    input  logic                clk,
    input  logic                rst,
    axis_byte_packer_if.master  bus
);
    localparam int NUM_BYTES = (W_OUT + BITS_PER_WORD - 1) / BITS_PER_WORD;
    localparam int ASM_W     = NUM_BYTES * BITS_PER_WORD;
    localparam int CNT_W     = $clog2(NUM_BYTES) + 1;
    localparam int IDLE_W    = (TIMEOUT_CLKS > 0) ? $clog2(TIMEOUT_CLKS + 1) : 1;

    logic [CNT_W-1:0]  cnt_r;
    logic [ASM_W-1:0]  asm_r;
    logic [IDLE_W-1:0] idle_r;
    logic              m_valid_r;
    logic [W_OUT-1:0]  m_data_r;
    logic              overflow_r;
    logic              frame_drop_r;

    logic [ASM_W-1:0]  ins_s;
    logic [W_OUT-1:0]  word_s;
    logic              complete_s;
    logic              load_s;
    logic              timeout_hit_s;
    logic              m_valid_next_s;

    // Merge the incoming byte into its slot and decide completion, loading and timeout.
    always_comb begin
        ins_s = asm_r;
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (cnt_r == CNT_W'(k)) begin
                ins_s[k*BITS_PER_WORD +: BITS_PER_WORD] = bus.s_data;
            end else begin
                ins_s[k*BITS_PER_WORD +: BITS_PER_WORD] = asm_r[k*BITS_PER_WORD +: BITS_PER_WORD];
            end
        end
        word_s     = ins_s[W_OUT-1:0];
        complete_s = bus.s_valid && (cnt_r == CNT_W'(NUM_BYTES - 1));
        load_s     = complete_s && (!m_valid_r || bus.m_ready);
        // A byte arriving on the timeout cycle wins, so s_valid masks the hit.
        timeout_hit_s = (TIMEOUT_CLKS != 0) && !bus.s_valid && (cnt_r != CNT_W'(0))
                        && (idle_r == IDLE_W'(TIMEOUT_CLKS - 1));
        if (load_s) begin
            m_valid_next_s = 1'b1;
        end else if (m_valid_r && bus.m_ready) begin
            m_valid_next_s = 1'b0;
        end else begin
            m_valid_next_s = m_valid_r;
        end
    end

    // Assembly state: byte counter, assembly register and inter-byte idle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= CNT_W'(0);
            asm_r  <= ASM_W'(0);
            idle_r <= IDLE_W'(0);
        end else if (bus.s_valid) begin
            idle_r <= IDLE_W'(0);
            if (complete_s) begin
                cnt_r <= CNT_W'(0);
                asm_r <= ASM_W'(0);
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
                asm_r <= ins_s;
            end
        end else if (timeout_hit_s) begin
            cnt_r  <= CNT_W'(0);
            asm_r  <= ASM_W'(0);
            idle_r <= IDLE_W'(0);
        end else if (cnt_r == CNT_W'(0)) begin
            idle_r <= IDLE_W'(0);
        end else begin
            idle_r <= idle_r + IDLE_W'(1);
        end
    end

    // Output register and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_r    <= 1'b0;
            m_data_r     <= W_OUT'(0);
            overflow_r   <= 1'b0;
            frame_drop_r <= 1'b0;
        end else begin
            m_valid_r    <= m_valid_next_s;
            overflow_r   <= complete_s && !load_s;
            frame_drop_r <= timeout_hit_s;
            if (load_s) begin
                m_data_r <= word_s;
            end else begin
                m_data_r <= m_data_r;
            end
        end
    end

    assign bus.m_valid    = m_valid_r;
    assign bus.m_data     = m_data_r;
    assign bus.overflow   = overflow_r;
    assign bus.frame_drop = frame_drop_r;
endmodule
